vip_clocked_video_out: RTL and testbench

//  Parametrised Avalon-ST video to clocked-video output stage: drives the display/VGA pins from the processed pixel stream.

---
 rtl/vip_cvo_pkg.sv | 34 +++
 rtl/vip_cvo_fifo.sv | 58 +++++
 rtl/vip_clocked_video_out.sv | 246 ++++++++++++++++++++++++
 tb/tb_vip_clocked_video_out.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vip_cvo_pkg.sv
// Shared types and helpers for the clocked-video output stage.
// States, packet types and frame-total helpers.
package vip_cvo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    LOCK,
    RUN,
    RESYNC
  } cvo_state_t;

  localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;
  localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;

  function automatic int h_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vip_cvo_fifo.sv
// Synchronous pixel FIFO with flush and show-ahead head.
// A pop on a full FIFO frees the slot for a same-cycle push.
module vip_cvo_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push)
        wr_q <= wr_q + 1'b1;
      if (do_pop)
        rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/vip_clocked_video_out.sv
// Avalon-ST video to clocked-video output with frame lock,
// start-of-frame checking and underflow resync.
module vip_clocked_video_out
  import vip_cvo_pkg::*;
#(
  parameter int BITS_PER_SYMBOL = 8,
  parameter int SYMBOLS         = 3,
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter bit SYNC_ACT_HIGH   = 1'b0,
  parameter int FIFO_DEPTH      = 64
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic [BITS_PER_SYMBOL*SYMBOLS-1:0] din_data,
  input  logic                               din_valid,
  input  logic                               din_sop,
  input  logic                               din_eop,
  output logic                               din_ready,
  output logic [BITS_PER_SYMBOL*SYMBOLS-1:0] vid_data,
  output logic                               vid_datavalid,
  output logic                               vid_h_sync,
  output logic                               vid_v_sync,
  output logic                               vid_h,
  output logic                               vid_v,
  output logic                               vid_f,
  output logic                               underflow,
  output logic                               locked
);

  localparam int DW    = BITS_PER_SYMBOL * SYMBOLS;
  localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int NPIX  = H_ACTIVE * V_ACTIVE;
  localparam int PW    = $clog2(NPIX + 1);
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC;

  localparam logic [PW-1:0] NPIX_C = PW'(NPIX);

  cvo_state_t    state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [31:0]   h32, v32;
  logic          vpkt_q, vpkt_d;
  logic [PW-1:0] pix_q, pix_d;
  logic          unf_q, unf_d;

  logic [DW-1:0] data_q, data_d;
  logic          dv_q, dv_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          hb_q, hb_d;
  logic          vb_q, vb_d;

  logic          f_push, f_pop, f_flush;
  logic [DW:0]   f_wdata, f_rdata;
  logic          f_empty, f_full;

  logic          active, frame_end, origin;
  logic          beat, is_video, pix_beat;
  logic          run_out, in_run;

  vip_cvo_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .flush (f_flush),
    .push  (f_push),
    .wdata (f_wdata),
    .pop   (f_pop),
    .rdata (f_rdata),
    .empty (f_empty),
    .full  (f_full)
  );

  assign h32       = 32'(h_q);
  assign v32       = 32'(v_q);
  assign active    = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
  assign frame_end = (h32 == H_TOT - 1) && (v32 == V_TOT - 1);
  assign origin    = (h_q == '0) && (v_q == '0);
  assign run_out   = enable && (state_q != IDLE);
  assign in_run    = enable && (state_q == RUN);

  always_comb begin
    din_ready = 1'b0;
    unique case (1'b1)
      (state_q == LOCK),
      (state_q == RUN):    din_ready = !f_full;
      (state_q == HUNT),
      (state_q == RESYNC): din_ready = 1'b1;
      default:             din_ready = 1'b0;
    endcase
  end

  assign beat     = din_valid && din_ready;
  assign is_video = (din_data[3:0] == PKT_TYPE_VIDEO);
  assign pix_beat = beat && !din_sop && vpkt_q;
  assign f_wdata  = {(pix_q == '0), din_data};
  assign f_push   = pix_beat && (pix_q != NPIX_C)
                 && ((state_q == LOCK) || (state_q == RUN));

  // The sop beat carries the packet type and is never buffered.
  always_comb begin
    vpkt_d = vpkt_q;
    pix_d  = pix_q;
    if (beat && din_sop) begin
      vpkt_d = is_video && !din_eop;
      pix_d  = '0;
    end else if (pix_beat) begin
      if (pix_q != NPIX_C)
        pix_d = pix_q + 1'b1;
      if (din_eop)
        vpkt_d = 1'b0;
    end
    if (state_q == IDLE)
      vpkt_d = 1'b0;
  end

  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run_out) begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (h32 == H_TOT - 1) begin
        h_d = '0;
        v_d = (v32 == V_TOT - 1) ? '0 : v_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unf_d   = unf_q;
    f_pop   = 1'b0;
    f_flush = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      unf_d   = 1'b0;
      f_flush = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = HUNT;
          f_flush = 1'b1;
        end
        HUNT: begin
          if (beat && din_sop && is_video)
            state_d = LOCK;
        end
        LOCK: begin
          // Stray non-SOF pixels ahead of a frame can never lock.
          if (!f_empty && !f_rdata[DW])
            f_pop = 1'b1;
          else if (frame_end && !f_empty)
            state_d = RUN;
        end
        RUN: begin
          if (active) begin
            if (f_empty) begin
              state_d = RESYNC;
              unf_d   = 1'b1;
            end else begin
              f_pop = 1'b1;
              if (f_rdata[DW] != origin) begin
                state_d = RESYNC;
                unf_d   = 1'b1;
              end
            end
          end
        end
        RESYNC: begin
          f_flush = 1'b1;
          state_d = HUNT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hs_d   = (run_out && h32 >= HS_LO && h32 < HS_HI) ~^ SYNC_ACT_HIGH;
    vs_d   = (run_out && v32 >= VS_LO && v32 < VS_HI) ~^ SYNC_ACT_HIGH;
    hb_d   = run_out && (h32 >= H_ACTIVE);
    vb_d   = run_out && (v32 >= V_ACTIVE);
    dv_d   = in_run && active;
    data_d = '0;
    if (in_run && active && !f_empty)
      data_d = f_rdata[DW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      vpkt_q  <= 1'b0;
      pix_q   <= '0;
      unf_q   <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      hs_q    <= ~SYNC_ACT_HIGH;
      vs_q    <= ~SYNC_ACT_HIGH;
      hb_q    <= 1'b0;
      vb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      vpkt_q  <= vpkt_d;
      pix_q   <= pix_d;
      unf_q   <= unf_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      hb_q    <= hb_d;
      vb_q    <= vb_d;
    end
  end

  assign vid_data      = data_q;
  assign vid_datavalid = dv_q;
  assign vid_h_sync    = hs_q;
  assign vid_v_sync    = vs_q;
  assign vid_h         = hb_q;
  assign vid_v         = vb_q;
  assign vid_f         = 1'b0;
  assign underflow     = unf_q;
  assign locked        = (state_q == RUN);

endmodule

// File: tb/tb_vip_clocked_video_out.sv
// Directed bench for vip_clocked_video_out on a tiny 8x5 raster.
// Frame position c = k-2 clocks after enable drives the pins.
module tb_vip_clocked_video_out;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [23:0] din_data;
  logic        din_valid, din_sop, din_eop;
  logic        din_ready;
  logic [23:0] vid_data;
  logic        vid_datavalid, vid_h_sync, vid_v_sync;
  logic        vid_h, vid_v, vid_f;
  logic        underflow, locked;

  int k;
  int tests;
  int fails;

  vip_clocked_video_out #(
    .BITS_PER_SYMBOL (8),
    .SYMBOLS         (3),
    .H_ACTIVE        (4),
    .H_FP            (1),
    .H_SYNC          (2),
    .H_BP            (1),
    .V_ACTIVE        (2),
    .V_FP            (1),
    .V_SYNC          (1),
    .V_BP            (1),
    .SYNC_ACT_HIGH   (1'b0),
    .FIFO_DEPTH      (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .din_data      (din_data),
    .din_valid     (din_valid),
    .din_sop       (din_sop),
    .din_eop       (din_eop),
    .din_ready     (din_ready),
    .vid_data      (vid_data),
    .vid_datavalid (vid_datavalid),
    .vid_h_sync    (vid_h_sync),
    .vid_v_sync    (vid_v_sync),
    .vid_h         (vid_h),
    .vid_v         (vid_v),
    .vid_f         (vid_f),
    .underflow     (underflow),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s k=%0d: got %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic wait_to(input int kt);
    if (k > kt) begin
      tests++;
      fails++;
      $error("FAIL sched: at k=%0d, target %0d passed", k, kt);
    end
    while (k < kt) step();
  endtask

  task automatic send(input logic [23:0] d, input logic s,
                      input logic e);
    logic r;
    int   g;
    din_data  = d;
    din_sop   = s;
    din_eop   = e;
    din_valid = 1'b1;
    g = 0;
    do begin
      r = din_ready;
      step();
      g++;
    end while (!r && g < 60);
    if (!r) begin
      tests++;
      fails++;
      $error("FAIL send: ready stuck 0, got 0 expected 1");
    end
    din_valid = 1'b0;
    din_sop   = 1'b0;
    din_eop   = 1'b0;
  endtask

  task automatic send_video(input logic [23:0] base, input int n,
                            input bit eop_last);
    send(24'h0, 1'b1, 1'b0);
    for (int i = 1; i <= n; i++)
      send(base + 24'(i), 1'b0, eop_last && (i == n));
  endtask

  task automatic chk_frame(input int k0, input int k1,
                           input logic [23:0] base, input bit run);
    int c, h, v;
    bit act;
    for (int kk = k0; kk <= k1; kk++) begin
      wait_to(kk);
      c   = kk - 2;
      h   = c % 8;
      v   = (c / 8) % 5;
      act = (h < 4) && (v < 2);
      chk("hsync", 32'(vid_h_sync), 32'(!(h == 5 || h == 6)));
      chk("vsync", 32'(vid_v_sync), 32'(v != 3));
      chk("hblank", 32'(vid_h), 32'(h >= 4));
      chk("vblank", 32'(vid_v), 32'(v >= 2));
      chk("dv", 32'(vid_datavalid), 32'(run && act));
      chk("data", 32'(vid_data),
          (run && act) ? 32'(base) + 32'(v * 4 + h + 1) : 32'h0);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_hs"}, 32'(vid_h_sync), 32'h1);
    chk({tag, "_vs"}, 32'(vid_v_sync), 32'h1);
    chk({tag, "_dv"}, 32'(vid_datavalid), 32'h0);
    chk({tag, "_data"}, 32'(vid_data), 32'h0);
    chk({tag, "_hb"}, 32'(vid_h), 32'h0);
    chk({tag, "_unf"}, 32'(underflow), 32'h0);
    chk({tag, "_lock"}, 32'(locked), 32'h0);
    chk({tag, "_rdy"}, 32'(din_ready), 32'h0);
    chk({tag, "_f"}, 32'(vid_f), 32'h0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    k         = 0;
    reset_n   = 1'b0;
    enable    = 1'b0;
    din_data  = '0;
    din_valid = 1'b0;
    din_sop   = 1'b0;
    din_eop   = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset_n = 1'b1;
    step();
    chk_idle("idle");

    // 1: free-running timing, no lock
    enable = 1'b1;
    k = 0;
    chk_frame(2, 25, 24'h0, 1'b0);
    chk("t1_lock", 32'(locked), 32'h0);

    // 2: lock onto an 8-pixel frame
    send_video(24'h000000, 8, 1'b1);
    chk_frame(35, 40, 24'h0, 1'b0);
    chk("t2_lock_pre", 32'(locked), 32'h0);
    wait_to(41);
    chk("t2_lock", 32'(locked), 32'h1);
    chk_frame(42, 53, 24'h000000, 1'b1);

    // 5: short packet then a new frame -> SOF mismatch at (2,1)
    send_video(24'h000020, 6, 1'b1);
    send(24'h0, 1'b1, 1'b0);
    send(24'h000099, 1'b0, 1'b0);
    send(24'h00009A, 1'b0, 1'b0);
    chk_frame(64, 81, 24'h0, 1'b1);
    chk_frame(82, 91, 24'h000020, 1'b1);
    chk("t5_unf_pre", 32'(underflow), 32'h0);
    wait_to(92);
    chk("t5_unf", 32'(underflow), 32'h1);
    chk("t5_dv", 32'(vid_datavalid), 32'h1);
    chk("t5_lock", 32'(locked), 32'h0);
    wait_to(93);
    chk("t5_hunt_rdy", 32'(din_ready), 32'h1);
    chk("t5_unf_sticky", 32'(underflow), 32'h1);

    enable = 1'b0;
    step();
    chk_idle("dis1");

    // 3+4: control packet first, then starve after one frame
    enable = 1'b1;
    k = 0;
    send(24'h00000F, 1'b1, 1'b0);
    send(24'hAAAAAA, 1'b0, 1'b0);
    send(24'hBBBBBB, 1'b0, 1'b1);
    send_video(24'h000030, 8, 1'b1);
    chk_frame(14, 40, 24'h0, 1'b0);
    wait_to(41);
    chk("t3_lock", 32'(locked), 32'h1);
    chk_frame(42, 81, 24'h000030, 1'b1);
    chk("t4_unf_pre", 32'(underflow), 32'h0);
    wait_to(82);
    chk("t4_unf", 32'(underflow), 32'h1);
    chk("t4_dv", 32'(vid_datavalid), 32'h1);
    chk("t4_data", 32'(vid_data), 32'h0);
    wait_to(83);
    chk("t4_lock", 32'(locked), 32'h0);
    chk("t4_hunt_rdy", 32'(din_ready), 32'h1);
    send_video(24'h000040, 8, 1'b1);
    wait_to(121);
    chk("t4_relock", 32'(locked), 32'h1);
    chk("t4_unf_sticky", 32'(underflow), 32'h1);
    chk_frame(122, 125, 24'h000040, 1'b1);

    // 6: drop enable mid-line, then async reset mid-frame
    enable = 1'b0;
    step();
    chk_idle("dis2");
    enable = 1'b1;
    k = 0;
    send_video(24'h000050, 8, 1'b1);
    wait_to(44);
    chk("t6_lock", 32'(locked), 32'h1);
    chk("t6_data", 32'(vid_data), 32'h000053);
    chk("t6_dv", 32'(vid_datavalid), 32'h1);
    reset_n = 1'b0;
    #1;
    chk_idle("areset");
    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
